dht11_responder: RTL and testbench
==================================

Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the slave end of the single-wire DHT11 protocol.
- Detects the host start pulse on the open-drain `dat_io` line, then drives the ACK sequence and a 40-bit frame: 4 payload bytes plus checksum, MSB first.
- Used on-FPGA for loopback testing of the DHT11 host controller and as a stand-in when no physical sensor is fitted.

Parameters:
- CLKS_PER_US, 50, clk cycles per 1 µs tick (50 MHz default).
- START_MIN_US, 18000, minimum host low pulse accepted as start.
- RESP_WAIT_US, 30, delay from host release to ACK low; must exceed the host's 20 µs driven-high phase.
- ACK_LOW_US, 80, ACK low duration.
- ACK_HIGH_US, 80, ACK released-high duration.
- BIT_LOW_US, 50, low preamble per bit and end-of-frame low.
- BIT0_HIGH_US, 26, high time for a '0'.
- BIT1_HIGH_US, 70, high time for a '1'.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- dat_io  inout  1  DHT11 bus; driven 0 when dat_oe=1, else high-Z (external pull-up)
- payload  in  32  {hum_int, hum_dec, temp_int, temp_dec}; sampled once per frame
- busy  out  1  high from start detection until return to IDLE
- done  out  1  one-cycle pulse when a full frame has been sent
- short_start  out  1  one-cycle pulse when a low pulse shorter than START_MIN_US is rejected
- frame_cnt  out  8  frames completed, wraps 255->0
- dat_oe  out  1  internal drive-low enable, exported for debug

Behaviour:
- Reset state:
  - dat_oe=0 (bus released); busy=0, done=0, short_start=0, frame_cnt=0.
  - State IDLE; µs counter 0; shift register 0.
  - Asserting rst_n mid-frame releases the bus within the same clk edge (asynchronous).
- Input path: `dat_io` passes through a 2-flop synchronizer to give `din_s`. All line decisions use `din_s`.
- µs tick: one-cycle pulse every CLKS_PER_US clocks, free-running. Phase counter is 16 bits and clears on every state entry.
- A phase of N µs ends on the Nth tick after entry. The bench tolerance is ±1 µs plus 2 clk of synchronizer latency.
- Checksum: (payload[31:24]+payload[23:16]+payload[15:8]+payload[7:0]) mod 256.
- Frame: shift register = {payload, checksum}, loaded on exit from START_LOW.
- States:
  - IDLE: dat_oe=0. On `din_s` falling, go to START_LOW with counter 0.
  - START_LOW: count ticks while `din_s`=0; counter saturates at 65535.
    - On `din_s` rising with count ≥ START_MIN_US: load frame, busy=1, go to RESP_WAIT.
    - On `din_s` rising with count < START_MIN_US: pulse short_start, return to IDLE.
  - RESP_WAIT: dat_oe=0 for RESP_WAIT_US, then go to ACK_LOW. Line activity is ignored.
  - ACK_LOW: dat_oe=1 for ACK_LOW_US, then go to ACK_HIGH.
  - ACK_HIGH: dat_oe=0 for ACK_HIGH_US; bit index=0; go to BIT_LOW.
  - BIT_LOW: dat_oe=1 for BIT_LOW_US, then go to BIT_HIGH.
  - BIT_HIGH: dat_oe=0 for BIT1_HIGH_US if the current MSB is 1, else BIT0_HIGH_US.
    - Then shift left and increment bit index.
    - If index reaches 40, go to END_LOW; else go to BIT_LOW.
  - END_LOW: dat_oe=1 for BIT_LOW_US, then go to DONE.
  - DONE: dat_oe=0; done=1 for one cycle; frame_cnt+1; busy=0; go to IDLE.
- The responder never drives high. Host activity after START_LOW is ignored until IDLE.
- A low pulse that begins in DONE is not missed: IDLE samples `din_s` level, not an edge, on entry.
- `payload` changes after the frame load do not affect the frame in flight.

Optional Feature:
- Macro DHT11_RESP_CORRUPT_EN.
- When defined:
  - Adds input port `corrupt_cksum` (1 bit), sampled at frame load.
  - If high, the transmitted checksum is bitwise inverted, so the host reports an error.
- When undefined: the port is absent and the checksum is always correct.

Decomposition:
- Package dht11_pkg:
  - State encoding constants (IDLE..DONE).
  - FRAME_BITS=40.
  - Default timing constants (µs), shared with the host controller for consistency.
- Sub-module us_tick_gen (parameter CLKS_PER_US, ports clk, rst_n, tick): prescaler reusable by the host side.

Test Plan:
- Host model pulls low 19000 µs, releases; payload=0x3A00_1900 -> ACK low 80 µs/high 80 µs.
  - Then 40 bits decode to 0x3A00190053; done pulses once; frame_cnt=1.
- Host low pulse of 5000 µs -> short_start pulses, dat_oe stays 0, busy stays 0, no ACK.
- payload=0xFFFF_FFFF -> checksum 0xFC; all payload bits have high ≈70 µs; checksum bits 1,0 have high ≈26 µs.
- Assert rst_n low during bit 12 -> dat_oe=0 immediately; next 19000 µs start yields a full correct frame.
- 256 back-to-back frames -> frame_cnt wraps to 0; done count=256.
- With DHT11_RESP_CORRUPT_EN and corrupt_cksum=1, payload=0x0102_0304 -> checksum sent as 0xF5 (~0x0A).

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM encoding, frame size, default protocol timing (µs)
// and the checksum helper used by both responder and host controller.
package dht11_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RESP_WAIT,
        S_ACK_LOW,
        S_ACK_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW,
        S_DONE
    } state_t;

    localparam int FRAME_BITS = 40;

    localparam int DEF_CLKS_PER_US  = 50;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_RESP_WAIT_US = 30;
    localparam int DEF_ACK_LOW_US   = 80;
    localparam int DEF_ACK_HIGH_US  = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;

    function automatic logic [7:0] checksum(input logic [31:0] p);
        return p[31:24] + p[23:16] + p[15:8] + p[7:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running microsecond prescaler: one-cycle tick every CLKS_PER_US clocks.
module us_tick_gen #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with ACK and a 40-bit frame.
// Optional macro DHT11_RESP_CORRUPT_EN adds corrupt_cksum to send an inverted checksum.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int RESP_WAIT_US = DEF_RESP_WAIT_US,
    parameter int ACK_LOW_US   = DEF_ACK_LOW_US,
    parameter int ACK_HIGH_US  = DEF_ACK_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         dat_io,
    input  logic [31:0] payload,
    output logic        busy,
    output logic        done,
    output logic        short_start,
    output logic [7:0]  frame_cnt,
`ifdef DHT11_RESP_CORRUPT_EN
    input  logic        corrupt_cksum,
`endif
    output logic        dat_oe
);

    state_t                  state, state_nxt;
    logic                    tick;
    logic                    din_p0, din_s;
    logic [15:0]             cnt;
    logic [15:0]             phase_len;
    logic                    phase_end;
    logic [FRAME_BITS-1:0]   shreg;
    logic [5:0]              bit_idx;
    logic                    load, shift;
    logic [7:0]              cksum_tx;

    us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Open-drain: the responder only ever pulls the line low.
    assign dat_io = dat_oe ? 1'b0 : 1'bz;

`ifdef DHT11_RESP_CORRUPT_EN
    assign cksum_tx = checksum(payload) ^ {8{corrupt_cksum}};
`else
    assign cksum_tx = checksum(payload);
`endif

    always_comb begin
        phase_len = 16'd1;
        case (state)
            S_RESP_WAIT:          phase_len = 16'(RESP_WAIT_US);
            S_ACK_LOW:            phase_len = 16'(ACK_LOW_US);
            S_ACK_HIGH:           phase_len = 16'(ACK_HIGH_US);
            S_BIT_LOW, S_END_LOW: phase_len = 16'(BIT_LOW_US);
            S_BIT_HIGH:           phase_len = shreg[FRAME_BITS-1] ? 16'(BIT1_HIGH_US)
                                                                  : 16'(BIT0_HIGH_US);
            default:              phase_len = 16'd1;
        endcase
    end

    // A phase of N µs ends on the Nth tick after entry.
    assign phase_end = tick && (cnt == phase_len - 16'd1);

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        shift       = 1'b0;
        short_start = 1'b0;
        dat_oe      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!din_s) state_nxt = S_START_LOW;
            end
            S_START_LOW: begin
                if (din_s) begin
                    if (cnt >= 16'(START_MIN_US)) begin
                        load      = 1'b1;
                        state_nxt = S_RESP_WAIT;
                    end else begin
                        short_start = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                end
            end
            S_RESP_WAIT: begin
                busy = 1'b1;
                if (phase_end) state_nxt = S_ACK_LOW;
            end
            S_ACK_LOW: begin
                busy   = 1'b1;
                dat_oe = 1'b1;
                if (phase_end) state_nxt = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                busy = 1'b1;
                if (phase_end) state_nxt = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                busy   = 1'b1;
                dat_oe = 1'b1;
                if (phase_end) state_nxt = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                busy = 1'b1;
                if (phase_end) begin
                    shift     = 1'b1;
                    state_nxt = (bit_idx == 6'(FRAME_BITS - 1)) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                busy   = 1'b1;
                dat_oe = 1'b1;
                if (phase_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            din_p0    <= 1'b1;
            din_s     <= 1'b1;
            cnt       <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            state  <= state_nxt;
            din_p0 <= dat_io;
            din_s  <= din_p0;

            // Counter saturates so an arbitrarily long start pulse is still accepted.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (tick && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            if (load) begin
                shreg <= {payload, cksum_tx};
            end else if (shift) begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end

            if (state == S_ACK_HIGH) begin
                bit_idx <= '0;
            end else if (shift) begin
                bit_idx <= bit_idx + 6'd1;
            end

            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model pulls the bus, records line segments and
// decodes frames against a reference built from payload bytes and their sum.
module tb_dht11_responder;

    localparam int CLKS = 1;
    localparam int SMIN = 20;
    localparam int RESP = 4;
    localparam int ACKL = 6;
    localparam int ACKH = 6;
    localparam int BLOW = 2;
    localparam int B0   = 2;
    localparam int B1   = 5;
    localparam int TOL  = 1;
    localparam int NSEG = 4 + 2 * 40 + 1;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_low = 1'b0;
    logic [31:0] payload = 32'h0;
`ifdef DHT11_RESP_CORRUPT_EN
    logic        corrupt_cksum = 1'b0;
`endif
    wire         dat_io;
    logic        busy, done, short_start, dat_oe, tick5;
    logic [7:0]  frame_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int exp_frames = 0;

    int   done_cnt = 0, short_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    int   tick5_cnt = 0, tick5_since = 0, tick5_last = 0;
    seg_t seg_q[$];
    logic cur_lvl = 1'b1;
    int   run_len = 0;

    pullup (dat_io);
    assign dat_io = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_responder #(
        .CLKS_PER_US  (CLKS),
        .START_MIN_US (SMIN),
        .RESP_WAIT_US (RESP),
        .ACK_LOW_US   (ACKL),
        .ACK_HIGH_US  (ACKH),
        .BIT_LOW_US   (BLOW),
        .BIT0_HIGH_US (B0),
        .BIT1_HIGH_US (B1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dat_io      (dat_io),
        .payload     (payload),
        .busy        (busy),
        .done        (done),
        .short_start (short_start),
        .frame_cnt   (frame_cnt),
`ifdef DHT11_RESP_CORRUPT_EN
        .corrupt_cksum (corrupt_cksum),
`endif
        .dat_oe      (dat_oe)
    );

    us_tick_gen #(.CLKS_PER_US(5)) u_tick5 (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick5)
    );

    // Line recorder and event counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (dat_io === cur_lvl) begin
            run_len <= run_len + 1;
        end else begin
            seg_q.push_back('{cur_lvl, run_len});
            cur_lvl <= dat_io;
            run_len <= 1;
        end
        done_cnt  <= done_cnt + int'(done);
        short_cnt <= short_cnt + int'(short_start);
        oe_cnt    <= oe_cnt + int'(dat_oe);
        busy_cnt  <= busy_cnt + int'(busy);
        if (tick5) begin
            tick5_cnt   <= tick5_cnt + 1;
            tick5_last  <= tick5_since + 1;
            tick5_since <= 0;
        end else begin
            tick5_since <= tick5_since + 1;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint d;
        n_tests++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    function automatic logic [39:0] model_frame(input logic [31:0] p, input bit corrupt_v);
        int sum;
        logic [7:0] ck;
        sum = int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
        ck  = 8'(sum % 256);
        if (corrupt_v) ck = 8'(255 - int'(ck));
        return {p, ck};
    endfunction

    task automatic run_frame(input logic [31:0] p, input bit corrupt_v, input int low_us, input bit decode);
        int          base, d0, bad;
        bit          seen;
        logic [39:0] exp_f, got;
        payload = p;
`ifdef DHT11_RESP_CORRUPT_EN
        corrupt_cksum = corrupt_v;
`endif
        exp_f = model_frame(p, corrupt_v);
        d0 = done_cnt;
        @(posedge clk); #1;
        base = seg_q.size() + 1;
        host_low = 1'b1;
        repeat (low_us * CLKS) @(posedge clk);
        #1 host_low = 1'b0;

        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1;
        end
        check("busy_rise", seen, 1);
        // Frame is latched by now; later input changes must not reach the line.
        payload = $urandom;
`ifdef DHT11_RESP_CORRUPT_EN
        corrupt_cksum = ~corrupt_v;
`endif
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        exp_frames++;
        check("done_once", done_cnt - d0, 1);
        check("frame_cnt", frame_cnt, exp_frames % 256);
        if (!decode) return;

        if (seg_q.size() < base + NSEG) begin
            check("seg_count", seg_q.size() - base, NSEG);
            return;
        end
        check("ack_delay", seg_q[base + 1].len, RESP + 2, TOL);
        check("ack_low", seg_q[base + 2].len, ACKL, TOL);
        check("ack_high", seg_q[base + 3].len, ACKH, TOL);
        bad = 0;
        got = '0;
        for (int k = 0; k < 40; k++) begin
            seg_t lo, hi;
            int   want;
            lo = seg_q[base + 4 + 2 * k];
            hi = seg_q[base + 5 + 2 * k];
            got[39 - k] = (hi.len > (B0 + B1) / 2);
            want = exp_f[39 - k] ? B1 : B0;
            if (lo.lvl !== 1'b0 || hi.lvl !== 1'b1) bad++;
            if (lo.len < BLOW - TOL || lo.len > BLOW + TOL) bad++;
            if (hi.len < want - TOL || hi.len > want + TOL) bad++;
        end
        check("frame_data", got, exp_f);
        check("bit_timing_errs", bad, 0);
        check("end_low", seg_q[base + 84].len, BLOW, TOL);
    endtask

    task automatic run_short(input int low_us);
        int s0, o0, b0, d0;
        s0 = short_cnt; o0 = oe_cnt; b0 = busy_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        host_low = 1'b1;
        repeat (low_us * CLKS) @(posedge clk);
        #1 host_low = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("short_pulse", short_cnt - s0, 1);
        check("short_no_oe", oe_cnt - o0, 0);
        check("short_no_busy", busy_cnt - b0, 0);
        check("short_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0;
        bit seen;

        repeat (4) @(posedge clk);
        #1;
        check("rst_dat_oe", dat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short_start, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_bus", dat_io, 1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        t0 = tick5_cnt;
        repeat (50) @(posedge clk);
        #1;
        check("tick_count", tick5_cnt - t0, 10);
        check("tick_period", tick5_last, 5);

        run_frame(32'h3A00_1900, 0, SMIN + 20, 1);
        run_short(8);
        run_frame(32'hFFFF_FFFF, 0, SMIN + 5, 1);
        for (int i = 0; i < 4; i++) begin
            run_frame($urandom, 0, int'($urandom_range(SMIN + 4, SMIN + 30)), 1);
        end
        for (int i = 0; i < 2; i++) begin
            run_short(int'($urandom_range(2, SMIN - 4)));
        end

        // Reset in the middle of bit 12 must release the bus immediately.
        payload = $urandom;
        @(posedge clk); #1;
        base = seg_q.size() + 1;
        host_low = 1'b1;
        repeat ((SMIN + 5) * CLKS) @(posedge clk);
        #1 host_low = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (seg_q.size() >= base + 4 + 2 * 12) seen = 1;
        end
        check("reach_bit12", seen, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_dat_oe", dat_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bus", dat_io, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_frames = 0;
        check("midrst_frame_cnt", frame_cnt, 0);
        repeat (3) @(posedge clk);
        run_frame($urandom, 0, SMIN + 6, 1);

`ifdef DHT11_RESP_CORRUPT_EN
        run_frame(32'h0102_0304, 1, SMIN + 6, 1);
        run_frame(32'h0102_0304, 0, SMIN + 6, 1);
`endif

        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_frames = 0;
        repeat (2) @(posedge clk);
        t0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            run_frame(32'h0, 0, SMIN + 4, 0);
        end
        check("wrap_frame_cnt", frame_cnt, 0);
        check("wrap_done_total", done_cnt - t0, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
